// File: rtl/vmem_pkg.sv
// ---------------------------------------------------------------------------
// vmem_pkg
//  Shared types and constants for the vector data-memory unit.
//  state_t    : sequencer states (IDLE, XFER, DRAIN, DONE)
//  CNT_MAX    : saturation ceiling of the access counter
//  LANE_IDX_W : bits needed to index n lanes (0 for a single lane)
// ---------------------------------------------------------------------------
package vmem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   function automatic int LANE_IDX_W(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/vec_dmem_unit_if.sv
// ---------------------------------------------------------------------------
// vec_dmem_unit_if
//  Request/response bundle between the CPU MEM stage and vec_dmem_unit.
//  master (CPU) drives : req_valid, req_we, req_addr, req_stride, req_vl,
//                        req_mask, req_wdata
//  slave  (unit) drives: req_ready, busy, done, rdata, oob
//  Lane i of req_wdata / rdata lives at [i*DATA_W +: DATA_W].
// ---------------------------------------------------------------------------
interface vec_dmem_unit_if
   import vmem_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int LANES    = 4,
   parameter int ADDR_W   = 32,
   parameter int STRIDE_W = 16
) ();

   localparam int VL_W = LANE_IDX_W(LANES) + 1;

   logic                    req_valid;
   logic                    req_ready;
   logic                    req_we;
   logic [ADDR_W-1:0]       req_addr;
   logic [STRIDE_W-1:0]     req_stride;
   logic [VL_W-1:0]         req_vl;
   logic [LANES-1:0]        req_mask;
   logic [LANES*DATA_W-1:0] req_wdata;
   logic                    busy;
   logic                    done;
   logic [LANES*DATA_W-1:0] rdata;
   logic                    oob;

   modport master (
      output req_valid, req_we, req_addr, req_stride, req_vl, req_mask, req_wdata,
      input  req_ready, busy, done, rdata, oob
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_stride, req_vl, req_mask, req_wdata,
      output req_ready, busy, done, rdata, oob
   );

endinterface

// File: rtl/dmem_bank.sv
// ---------------------------------------------------------------------------
// dmem_bank
//  Single-port synchronous RAM, one-cycle registered read.
//  clk   : rising-edge clock
//  we    : write enable for addr
//  addr  : word index
//  wdata : write data
//  rdata : mem[addr] as sampled at the previous edge (read-before-write)
//  MEM_INIT is accepted for interface compatibility; contents are never
//  cleared by reset.
// ---------------------------------------------------------------------------
module dmem_bank #(
  parameter int    DATA_W   = 32,
  parameter int    DEPTH    = 1024,
  parameter string MEM_INIT = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vec_dmem_unit.sv
// ---------------------------------------------------------------------------
// vec_dmem_unit
//  Strided, masked vector load/store engine in front of a single-port data
//  RAM. Walks one lane per cycle and counts every word touched.
//  clk        : rising-edge clock
//  reset      : synchronous, active-high; aborts a transfer in flight
//  bus        : request/response bundle (slave side), see vec_dmem_unit_if
//  access_cnt : RAM words read or written since reset, saturating
// ---------------------------------------------------------------------------
module vec_dmem_unit
   import vmem_pkg::*;
#(
   parameter int    DATA_W   = 32,
   parameter int    LANES    = 4,
   parameter int    DEPTH    = 1024,
   parameter int    ADDR_W   = 32,
   parameter int    STRIDE_W = 16,
   parameter string MEM_INIT = ""
) (
   input  logic           clk,
   input  logic           reset,
   vec_dmem_unit_if.slave bus,
   output logic [31:0]    access_cnt
);

   localparam int VL_W   = LANE_IDX_W(LANES) + 1;
   localparam int IDX_W  = ADDR_W + STRIDE_W;
   localparam int RAM_AW = $clog2(DEPTH);

   function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic inc);
      return (inc && (c != CNT_MAX)) ? c + 32'd1 : c;
   endfunction

   state_t                  state_q, state_d;
   logic [VL_W-1:0]         lane_q, vl_q, req_vl_eff;
   logic                    we_q;
   logic [IDX_W-1:0]        base_q, lane_idx;
   logic [STRIDE_W-1:0]     stride_q;
   logic [LANES-1:0]        mask_q;
   logic [LANES*DATA_W-1:0] wdata_q, rdata_q;
   logic                    oob_q;
   logic [31:0]             cnt_q;
   logic                    accept, last_lane, lane_mask, lane_act;
   logic [DATA_W-1:0]       lane_wdata, ram_rdata;
   logic                    vld_p1, cap_act_p1;
   logic [VL_W-1:0]         cap_lane_p1;

   assign accept     = bus.req_valid && (state_q == IDLE);
   assign req_vl_eff = (bus.req_vl > VL_W'(LANES)) ? VL_W'(LANES) : bus.req_vl;

   // ---- p0: lane select and address generation for the current lane ----
   always_comb begin
      lane_mask  = 1'b0;
      lane_wdata = '0;
      for (int l = 0; l < LANES; l++) begin
         if (lane_q == VL_W'(l)) begin
            lane_mask  = mask_q[l];
            lane_wdata = wdata_q[l*DATA_W +: DATA_W];
         end
      end
   end

   assign lane_act  = (state_q == XFER) && lane_mask;
   // Full-width index so oob sees the unwrapped value; the RAM takes the low bits.
   assign lane_idx  = base_q + IDX_W'(lane_q) * IDX_W'(stride_q);
   assign last_lane = (lane_q == vl_q - VL_W'(1));

   dmem_bank #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .MEM_INIT (MEM_INIT)
   ) u_bank (
      .clk   (clk),
      .we    (lane_act && we_q),
      .addr  (lane_idx[RAM_AW-1:0]),
      .wdata (lane_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = (req_vl_eff == '0) ? DONE : XFER;
         XFER:    if (last_lane) state_d = we_q ? DONE : DRAIN;
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         lane_q  <= '0;
         vld_p1  <= 1'b0;
         oob_q   <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= sat_inc(cnt_q, lane_act);
         vld_p1  <= (state_q == XFER) && !we_q;
         if (accept) begin
            lane_q <= '0;
            oob_q  <= 1'b0;
            // Lanes at or beyond vl never get written back, so start from zero.
            if (!bus.req_we) rdata_q <= '0;
         end else if (state_q == XFER) begin
            lane_q <= lane_q + VL_W'(1);
            if (lane_act && (lane_idx >= IDX_W'(DEPTH))) oob_q <= 1'b1;
         end
         // ---- p1: RAM data for the lane issued last cycle is now on ram_rdata ----
         if (vld_p1) begin
            for (int l = 0; l < LANES; l++) begin
               if (cap_lane_p1 == VL_W'(l))
                  rdata_q[l*DATA_W +: DATA_W] <= cap_act_p1 ? ram_rdata : '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q     <= bus.req_we;
         base_q   <= IDX_W'(bus.req_addr >> 2);
         stride_q <= bus.req_stride;
         vl_q     <= req_vl_eff;
         mask_q   <= bus.req_mask;
         wdata_q  <= bus.req_wdata;
      end
      cap_lane_p1 <= lane_q;
      cap_act_p1  <= lane_act;
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.oob       = (state_q == DONE) && oob_q;
   assign bus.rdata     = rdata_q;
   assign access_cnt    = cnt_q;

endmodule
